// File: rtl/monitor_tx_arbiter.sv
// monitor_tx_arbiter: fixed-priority share of the UART FIFO write port with trace starvation relief, registered write and trace drop counting
module monitor_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 8,
  parameter int DROP_TRACE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0] req_ready_o,
  input  logic             fifo_afull_i,
  output logic             fifo_wren_o,
  output logic [DW-1:0]    fifo_wdata_o,
  output logic [1:0]       grant_id_o,
  output logic [15:0]      drop_cnt_o,
  input  logic             drop_clr_i
);
  logic [N_REQ-1:0] grant;
  logic [1:0]       sel;
  logic             any;
  logic             drop;
  logic [7:0]       starve_q, starve_d;
  logic             forced_q, forced_d;
  logic             wren_q;
  logic [DW-1:0]    wdata_q;
  logic [1:0]       gid_q;
  logic [15:0]      drop_q, drop_d;
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++)
      if (req_valid_i[k]) begin
        sel = k[1:0];
        any = 1'b1;
      end
    if (forced_q && req_valid_i[0]) sel = '0;
    grant = '0;
    if (!fifo_afull_i && any) grant[sel] = 1'b1;
  end
  assign req_ready_o = rst_i ? '0 : grant | N_REQ'(DROP_TRACE != 0);
  assign drop = (DROP_TRACE != 0) && req_valid_i[0] && !grant[0];
  // Counter only advances on eligible cycles; a full FIFO freezes it rather than clearing it.
  always_comb begin
    starve_d = starve_q;
    forced_d = forced_q;
    if (grant[0] || !req_valid_i[0]) starve_d = '0;
    else if (!fifo_afull_i) begin
      starve_d = starve_q + 8'd1;
      if (starve_d == 8'(STARVE_MAX)) begin
        forced_d = 1'b1;
        starve_d = '0;
      end
    end
    if (grant[0]) forced_d = 1'b0;
  end
  assign drop_d = drop_clr_i ? '0 : (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      starve_q <= '0;
      forced_q <= 1'b0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      gid_q    <= '0;
      drop_q   <= '0;
    end else begin
      starve_q <= starve_d;
      forced_q <= forced_d;
      wren_q   <= |grant;
      wdata_q  <= |grant ? req_data_i[int'(sel)*DW +: DW] : wdata_q;
      gid_q    <= |grant ? sel : gid_q;
      drop_q   <= drop_d;
    end
  assign fifo_wren_o  = wren_q;
  assign fifo_wdata_o = wdata_q;
  assign grant_id_o   = gid_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_monitor_tx_arbiter.sv
// tb_monitor_tx_arbiter: directed self-checking bench for monitor_tx_arbiter
module tb_monitor_tx_arbiter;
  logic         clk, rst, afull, clr, wren;
  logic [3:0]   valid, ready;
  logic [255:0] data;
  logic [63:0]  wdata;
  logic [1:0]   gid;
  logic [15:0]  dcnt;
  int errors = 0, checks = 0;
  monitor_tx_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .fifo_afull_i(afull), .fifo_wren_o(wren),
    .fifo_wdata_o(wdata), .grant_id_o(gid), .drop_cnt_o(dcnt), .drop_clr_i(clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0; valid = '0; afull = 1'b0; clr = 1'b0;
    data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    #2 rst = 1'b1;
    #1;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %0b want 0", wren); end
    checks++; if (wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", gid); end
    checks++; if (dcnt !== 16'h0) begin errors++; $display("FAIL reset_dcnt got %h want 0", dcnt); end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", ready); end
    tick;
    tick;
    #3 rst = 1'b0;
    tick;
  endtask
  task automatic test_priority;
    logic [3:0] vv [4];
    int g [4];
    vv = '{4'b1110, 4'b1110, 4'b0110, 4'b0010};
    g  = '{3, 3, 2, 1};
    for (int i = 0; i < 4; i++) begin
      valid = vv[i];
      #1;
      checks++; if (ready !== (4'b0001 | (4'b0001 << g[i]))) begin errors++; $display("FAIL prio_ready[%0d] got %b want %b", i, ready, 4'b0001 | (4'b0001 << g[i])); end
      tick;
      checks++; if (wren !== 1'b1) begin errors++; $display("FAIL prio_wren[%0d] got %0b want 1", i, wren); end
      checks++; if (wdata !== 64'hA0 + 64'(g[i])) begin errors++; $display("FAIL prio_wdata[%0d] got %h want %h", i, wdata, 64'hA0 + 64'(g[i])); end
      checks++; if (gid !== 2'(g[i])) begin errors++; $display("FAIL prio_gid[%0d] got %0d want %0d", i, gid, g[i]); end
    end
    valid = '0;
    tick;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL prio_idle_wren got %0b want 0", wren); end
    checks++; if (wdata !== 64'hA1) begin errors++; $display("FAIL prio_hold_wdata got %h want a1", wdata); end
  endtask
  task automatic test_starvation;
    logic t0;
    valid = 4'b1001;
    #1;
    for (int c = 1; c <= 18; c++) begin
      t0 = (c % 9 == 0);
      checks++; if (ready !== (t0 ? 4'b0001 : 4'b1001)) begin errors++; $display("FAIL starve_ready[%0d] got %b want %b", c, ready, t0 ? 4'b0001 : 4'b1001); end
      tick;
      checks++; if (gid !== (t0 ? 2'd0 : 2'd3)) begin errors++; $display("FAIL starve_gid[%0d] got %0d want %0d", c, gid, t0 ? 0 : 3); end
      checks++; if (wdata !== (t0 ? 64'hA0 : 64'hA3)) begin errors++; $display("FAIL starve_wdata[%0d] got %h want %h", c, wdata, t0 ? 64'hA0 : 64'hA3); end
    end
    valid = '0;
    tick;
    checks++; if (dcnt !== 16'd16) begin errors++; $display("FAIL starve_drops got %0d want 16", dcnt); end
  endtask
  task automatic test_backpressure;
    valid = 4'b0100;
    afull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0001", c, ready); end
      tick;
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL bp_wren[%0d] got %0b want 0", c, wren); end
    end
    afull = 1'b0;
    #1;
    checks++; if (ready !== 4'b0101) begin errors++; $display("FAIL bp_release_ready got %b want 0101", ready); end
    tick;
    checks++; if (wren !== 1'b1 || wdata !== 64'hA2) begin errors++; $display("FAIL bp_write got wren=%0b data=%h want 1/a2", wren, wdata); end
    valid = '0;
    tick;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL bp_single got %0b want 0", wren); end
  endtask
  task automatic test_drop;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    checks++; if (dcnt !== 16'd0) begin errors++; $display("FAIL drop_clr0 got %0d want 0", dcnt); end
    afull = 1'b1;
    valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d] got %0b want 1", c, ready[0]); end
      tick;
    end
    checks++; if (dcnt !== 16'd10) begin errors++; $display("FAIL drop_cnt got %0d want 10", dcnt); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    valid = '0;
    checks++; if (dcnt !== 16'd0) begin errors++; $display("FAIL drop_clr_wins got %0d want 0", dcnt); end
  endtask
  task automatic test_saturation;
    valid = 4'b0001;
    repeat (65534) tick;
    checks++; if (dcnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", dcnt); end
    repeat (3) tick;
    checks++; if (dcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", dcnt); end
    valid = '0;
    afull = 1'b0;
    tick;
  endtask
  task automatic test_reset_midop;
    valid = 4'b1001;
    repeat (5) tick;
    checks++; if (wren !== 1'b1) begin errors++; $display("FAIL rst_pre_wren got %0b want 1", wren); end
    rst = 1'b1;
    #1;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_async_wren got %0b want 0", wren); end
    checks++; if (dcnt !== 16'h0) begin errors++; $display("FAIL rst_async_dcnt got %h want 0", dcnt); end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", ready); end
    #2 rst = 1'b0;
    #1;
    for (int c = 1; c <= 9; c++) begin
      checks++; if (ready !== (c == 9 ? 4'b0001 : 4'b1001)) begin errors++; $display("FAIL rst_starve_ready[%0d] got %b want %b", c, ready, c == 9 ? 4'b0001 : 4'b1001); end
      tick;
    end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL rst_starve_gid got %0d want 0", gid); end
    valid = '0;
  endtask
  initial begin
    test_reset;
    test_priority;
    test_starvation;
    test_backpressure;
    test_drop;
    test_saturation;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
